// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU between two requesters through
//               valid/ready handshakes. Define ALU_ARB_RR_EN for round-robin
//               arbitration; fixed priority (port 0 highest) otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req0Valid,
  input  logic        Req1Valid,
  output logic        Req0Ready,
  output logic        Req1Ready,
  input  logic [31:0] Req0A,
  input  logic [31:0] Req1A,
  input  logic [31:0] Req0B,
  input  logic [31:0] Req1B,
  input  logic        Req0Signed,
  input  logic        Req1Signed,
  input  logic [5:0]  Req0Func,
  input  logic [5:0]  Req1Func,
  output logic        Rsp0Valid,
  output logic        Rsp1Valid,
  input  logic        Rsp0Ready,
  input  logic        Rsp1Ready,
  output logic [31:0] Rsp0Data,
  output logic [31:0] Rsp1Data,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic        AluSigned,
  output logic [5:0]  AluFunc,
  input  logic [31:0] AluOut,
  output logic        Busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] CYC_LOAD = 4'(EXEC_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [3:0]  r_cyc_cnt;
  logic        r_owner;
  logic [31:0] r_result;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic        w_win;
  logic        w_owner_rsp_ready;

`ifdef ALU_ARB_RR_EN
  logic r_last_grant;

  // On a tie the port that did not win last time gets the ALU.
  always_comb begin
    w_grant0 = Req0Valid & (~Req1Valid | r_last_grant);
    w_grant1 = Req1Valid & (~Req0Valid | ~r_last_grant);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_win;
    end
  end
`else
  always_comb begin
    w_grant0 = Req0Valid;
    w_grant1 = Req1Valid & ~Req0Valid;
  end
`endif

  assign w_accept          = (r_state == S_IDLE) & (w_grant0 | w_grant1);
  assign w_win             = w_grant1;
  assign w_owner_rsp_ready = r_owner ? Rsp1Ready : Rsp0Ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  if (r_cyc_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  if (w_owner_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Ready is forced low while reset is held so no handshake can slip through.
  always_comb begin
    Req0Ready = reset & (r_state == S_IDLE) & w_grant0;
    Req1Ready = reset & (r_state == S_IDLE) & w_grant1;
    Rsp0Valid = (r_state == S_RESP) & ~r_owner;
    Rsp1Valid = (r_state == S_RESP) & r_owner;
    Busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      AluA      <= 32'd0;
      AluB      <= 32'd0;
      AluSigned <= 1'b0;
      AluFunc   <= 6'b000000;
      r_owner   <= 1'b0;
      r_cyc_cnt <= 4'd0;
      r_result  <= 32'd0;
    end else if (w_accept) begin
      AluA      <= w_win ? Req1A      : Req0A;
      AluB      <= w_win ? Req1B      : Req0B;
      AluSigned <= w_win ? Req1Signed : Req0Signed;
      AluFunc   <= w_win ? Req1Func   : Req0Func;
      r_owner   <= w_win;
      r_cyc_cnt <= CYC_LOAD;
    end else if (r_state == S_EXEC) begin
      if (r_cyc_cnt == 4'd0) begin
        r_result <= AluOut;
      end else begin
        r_cyc_cnt <= r_cyc_cnt - 4'd1;
      end
    end
  end

  assign Rsp0Data = r_result;
  assign Rsp1Data = r_result;

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle datapath's combinational ALU between two requesters: port 0 is the core datapath and port 1 is an auxiliary unit, such as a multiply/divide sequencer or debug unit. The block accepts one operation at a time through a valid/ready handshake and drives registered operands into the ALU. After a programmable settle time it captures the ALU result and returns it to the requester that issued the operation. It sits between the requesters and the ALU instance.

## Interface
Parameters:
- EXEC_CYCLES, 1, number of cycles operands are held stable on the ALU before ALUOut is sampled; legal range 1..15.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- Req0Valid, Req1Valid  in  1  request valid, per port.
- Req0Ready, Req1Ready  out  1  request accepted when both Valid and Ready are high at a rising edge.
- Req0A, Req1A, Req0B, Req1B  in  32  operands.
- Req0Signed, Req1Signed  in  1  signed-arithmetic select.
- Req0Func, Req1Func  in  6  ALU function code; passed through unchanged.
- Rsp0Valid, Rsp1Valid  out  1  result valid.
- Rsp0Ready, Rsp1Ready  in  1  result consumed when both Valid and Ready are high at a rising edge.
- Rsp0Data, Rsp1Data  out  32  result.
- AluA, AluB  out  32  ALU operand drive; registered.
- AluSigned  out  1  ALU Signed drive; registered.
- AluFunc  out  6  ALU ALUFunc drive; registered.
- AluOut  in  32  ALU result.
- Busy  out  1  high whenever the block is not in IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Arbitrate among asserted ReqNValid; ReqNReady is high only for the winner, and only in IDLE.
  - On handshake, latch A, B, Signed and Func into the Alu* registers, record the winning port in Owner, load CycCnt = EXEC_CYCLES-1, and go to EXEC.
- EXEC:
  - Alu* registers hold their values.
  - If CycCnt==0, capture AluOut into the result register and go to RESP; otherwise decrement CycCnt.
- RESP:
  - RspOwnerValid = 1 and RspOwnerData = result register; the other port's RspValid = 0.
  - On RspOwnerReady, go to IDLE.
  - A new request cannot be accepted in the same cycle the response is consumed.
- Requesters must hold their Valid and payload stable until accepted. ReqReady depends only on state and ReqValid, never on ReqReady of the other port.
- Rsp0Data and Rsp1Data both carry the result register at all times; only RspValid qualifies them.
- Arbitration without the macro is fixed priority: port 0 wins whenever Req0Valid=1.
- Busy = (state != IDLE).
- Reset values:
  - All Ready and RspValid outputs are 0.
  - Alu* registers, the result register, Owner and CycCnt are 0; AluFunc = 6'b000000 (ADD).
  - Busy = 0.
- Reset asserted mid-operation: return immediately to IDLE. The in-flight operation is dropped, no response is produced, and the requester must reissue.
- A ReqValid arriving while Busy is ignored: it waits, Ready stays 0.

## Timing
- Handshake at edge N: EXEC occupies cycles N+1 .. N+EXEC_CYCLES. RspValid is high from cycle N+EXEC_CYCLES+1.
- Minimum issue interval is EXEC_CYCLES+2 cycles (EXEC_CYCLES + RESP + IDLE).
- The ALU path from Alu* registers to AluOut to the result register may be constrained as an EXEC_CYCLES multicycle path.
- Response backpressure: RESP holds with data stable for as long as RspReady=0; there is no timeout.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit LastGrant register resets to 1, so port 0 wins the first tie.
  - On every accepted request, LastGrant takes the winner.
  - On a simultaneous request, the port != LastGrant wins.
  - A lone request always wins.
- ALU_ARB_RR_EN undefined: fixed priority with port 0 highest; no LastGrant register exists.

## Test plan
All scenarios use a real ALU instance on the Alu* ports, EXEC_CYCLES=1 unless stated.
- Port 0 ADD, A=5, B=7, Func=000000, Rsp0Ready=1 -> Rsp0Valid and Rsp0Data=12 exactly 2 cycles after the handshake; Rsp1Valid stays 0.
- Port 1 signed LT (Func=110101), A=32'hFFFFFFFF, B=1, Signed=1 -> Rsp1Data=1; with Signed=0 -> Rsp1Data=0.
- Both ports hold Valid for 4 operations:
  - Without ALU_ARB_RR_EN: grants 0,0,0,0 while port 0 stays valid.
  - With ALU_ARB_RR_EN: grants 0,1,0,1.
- EXEC_CYCLES=3, SUB (Func=000001), 10-3 with Rsp0Ready=0 for 5 cycles -> Rsp0Valid rises 4 cycles after the handshake and holds with Data=7 until Ready; Req1Ready=0 throughout.
- Reset pulsed low during EXEC -> all outputs return to their reset values asynchronously; no Rsp ever asserts for the dropped operation; the next request completes normally.
- Port 0 issues while port 1 is in RESP -> Req0Ready=0 until the cycle after Rsp1 is consumed, then accepted.
